qbus_master: RTL and testbench
==============================

# qbus_master

Synthesizable QBUS bus initiator for the vm2 environment. It turns single-word or single-byte read and write requests from a local request port into a complete QBUS transaction: the address phase with `sync_n`, then the data phase with `din_n`/`dout_n`, then the `rply_n` handshake. It is the initiator counterpart to the memory and terminal register responders already used around the vm2 core, and is intended for DMA-style masters and bus test drivers. All bus signals are active-low and inverted-data, as on the CPU pins.

## Interface
- `TIMEOUT`, 255: cycles to wait for `rply_n` asserted (DATA) or released (END) before aborting; used only with the timeout feature (see Configuration).
- `pin_clk_p`  in  1  block clock; all flops on the rising edge.
- `pin_dclo_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_byte`  in  1  byte write; ignored for reads.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  write data; bits [7:0] are used for byte writes.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  16  read data; valid while `done` is high and held until the next acceptance.
- `err`  out  1  timeout flag; qualified by `done`.
- `ad_out_n`  out  16  inverted address/data drive.
- `ad_oe`  out  1  enable for the external AD tristate.
- `ad_in_n`  in  16  inverted AD bus input.
- `sync_n`, `din_n`, `dout_n`, `wtbt_n`  out  1 each  QBUS strobes.
- `rply_n`  in  1  asynchronous reply from the responder.

## Operation
- States: IDLE, ADDR, SYNC, DATA, END, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On acceptance: latch addr/wr/byte/wdata, go to ADDR.
- **ADDR** (1 cycle)
  - `ad_oe` = 1, `ad_out_n` = ~addr.
  - `wtbt_n` = ~wr; it stays valid through the `sync_n` fall.
  - `sync_n` stays high (address setup).
- **SYNC** (1 cycle)
  - `sync_n` = 0; address held (hold time).
- **DATA**
  - Read: `ad_oe` = 0, `wtbt_n` = 1, `din_n` = 0.
  - Word write: `ad_out_n` = ~wdata.
  - Byte write: `ad_out_n` = ~wdata[7:0] on the lane selected by addr[0] (odd address → [15:8]); the other lane is driven ~0x00.
  - Write: `wtbt_n` = ~byte, `dout_n` = 0.
  - Leave when the synchronized reply `rply_s` is 0. For reads, `rdata` = ~`ad_in_n` is captured in that same cycle.
- **END**
  - `din_n` = `dout_n` = 1; write data stays driven.
  - Leave when `rply_s` = 1.
- **DONE** (1 cycle)
  - `sync_n` = 1, `ad_oe` = 0, `wtbt_n` = 1.
  - `done` = 1; next state IDLE.
- Only one strobe is active at a time.
- `sync_n` is never low outside SYNC, DATA and END.
- A request is never accepted outside IDLE; `req_*` inputs are ignored there.

## Timing
- Reset values (asynchronous on `pin_dclo_n` = 0):
  - state IDLE, `req_ready` = 1 after release.
  - `sync_n` = `din_n` = `dout_n` = `wtbt_n` = 1, `ad_oe` = 0, `ad_out_n` = 16'hFFFF.
  - `done` = 0, `err` = 0, `rdata` = 0.
- `rply_n` goes through a 2-flop synchronizer, so `rply_s` lags `rply_n` by 2 cycles.
- Minimum transaction with an immediate reply is 9 cycles from acceptance to `done`: ADDR 1 + SYNC 1 + DATA 3 + END 3 + DONE 1.
- Back-to-back requests: at least 2 cycles of `sync_n` high between transactions (DONE + ADDR).
- Reset mid-transaction: strobes are released at once with no `done` pulse; a new request may be accepted in the first cycle after release.
- `rply_n` asserted in IDLE or ADDR is ignored; DATA still waits for a fresh low.

## Configuration
- `QBUS_MASTER_TIMEOUT_EN`, when defined:
  - An 8-bit counter, cleared on entry to DATA and to END, increments each cycle in those states.
  - Reaching `TIMEOUT` in DATA: go to END with strobes off and `err` set; `rdata` is not updated.
  - Reaching `TIMEOUT` in END: go to DONE with `err` set.
- Without the macro there is no counter and `err` is tied 0; the block waits forever.

## Structure
- Package `qbus_pkg` holds the state encoding constants and the QBUS opcode/width constants (16-bit AD, byte-lane select rule).
- One sub-module, `qbus_sync2`: the 2-flop synchronizer for `rply_n`, reset to 1.

## Test plan
- **Word write** of 16'h1234 to 0o001000, responder replies 2 cycles after `dout_n` falls:
  - At the `sync_n` fall: `ad_out_n` = ~0o001000, `wtbt_n` = 0.
  - Data phase: `ad_out_n` = ~16'h1234, `wtbt_n` = 1.
  - `done` with `err` = 0.
- **Word read** from 0o177564, responder drives ~0o000200: `rdata` = 0o000200; `din_n` rises only after `rply_n` is low.
- **Byte write** of 8'hAB to 0o001001: in DATA, `ad_out_n`[15:8] = ~8'hAB, `wtbt_n` = 0; even address 0o001000 puts it on [7:0].
- **Timeout**, macro on, `TIMEOUT` = 16, responder silent:
  - `din_n` is released 16 cycles after entering DATA.
  - `done` with `err` = 1, `sync_n` high.
  - With the macro off, the block stays in DATA indefinitely.
- **Reset during DATA** (write): all strobes high and `ad_oe` = 0 within the same cycle, no `done`, `req_ready` = 1 after release.
- **Two back-to-back writes** with `req_valid` held high: the second `sync_n` fall comes at least 2 cycles after the first `sync_n` rise, and `done` pulses twice.

Source files
------------

// File: rtl/qbus_pkg.sv
// qbus_pkg: state encoding, bus width and byte-lane rule shared by the
// QBUS initiator files.
package qbus_pkg;

    localparam int AD_W = 16;
    localparam logic [AD_W-1:0] AD_IDLE_N = '1;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_SYNC = 3'd2,
        S_DATA = 3'd3,
        S_END  = 3'd4,
        S_DONE = 3'd5
    } qbus_state_t;

    // Byte data rides the high lane on odd addresses; the idle lane carries zero.
    function automatic logic [AD_W-1:0] lane_data(
        input logic            is_byte,
        input logic            odd,
        input logic [AD_W-1:0] wdata
    );
        if (!is_byte) begin
            return wdata;
        end
        return odd ? {wdata[7:0], 8'h00} : {8'h00, wdata[7:0]};
    endfunction

endpackage

// File: rtl/qbus_sync2.sv
// qbus_sync2: two-flop synchronizer for the asynchronous reply line,
// resetting to the released (high) level.
module qbus_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qbus_master.sv
// qbus_master: single-transfer QBUS initiator (address, data, reply handshake).
// Define QBUS_MASTER_TIMEOUT_EN to abort transfers whose reply never comes.
module qbus_master
    import qbus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            pin_clk_p,
    input  logic            pin_dclo_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic            req_byte,
    input  logic [AD_W-1:0] req_addr,
    input  logic [AD_W-1:0] req_wdata,
    output logic            done,
    output logic [AD_W-1:0] rdata,
    output logic            err,
    output logic [AD_W-1:0] ad_out_n,
    output logic            ad_oe,
    input  logic [AD_W-1:0] ad_in_n,
    output logic            sync_n,
    output logic            din_n,
    output logic            dout_n,
    output logic            wtbt_n,
    input  logic            rply_n
);

    qbus_state_t     state;
    qbus_state_t     state_nxt;
    logic [AD_W-1:0] addr_q;
    logic [AD_W-1:0] wdata_q;
    logic            wr_q;
    logic            byte_q;
    logic            is_write;
    logic            rply_s;
    logic            armed;
    logic            accept;
    logic            data_ack;
    logic            tmo_data;
    logic            tmo_end;

    qbus_sync2 u_sync (
        .clk   (pin_clk_p),
        .rst_n (pin_dclo_n),
        .d     (rply_n),
        .q     (rply_s)
    );

    assign accept   = (state == S_IDLE) && req_valid;
    assign is_write = (wr_q == OP_WRITE);
    assign data_ack = !rply_s && armed;

    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            byte_q  <= req_byte & req_wr;
        end
    end

    // A reply left asserted from before the address phase must be released
    // and re-asserted before it can complete the data phase.
    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            armed <= 1'b0;
        end else if (state == S_ADDR) begin
            armed <= 1'b0;
        end else if (rply_s) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            rdata <= '0;
        end else if (state == S_DATA && !is_write && data_ack) begin
            rdata <= ~ad_in_n;
        end
    end

`ifdef QBUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;
    logic       at_last;

    assign at_last  = (cnt == LAST);
    assign tmo_data = (state == S_DATA) && at_last && !data_ack;
    assign tmo_end  = (state == S_END) && at_last && !rply_s;

    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == S_DATA || state == S_END) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge pin_clk_p or negedge pin_dclo_n) begin
        if (!pin_dclo_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (tmo_data || tmo_end) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign tmo_data       = 1'b0;
    assign tmo_end        = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (req_valid) state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_SYNC;
            S_SYNC: state_nxt = S_DATA;
            S_DATA: if (data_ack || tmo_data) state_nxt = S_END;
            S_END:  if (rply_s || tmo_end) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        sync_n    = 1'b1;
        din_n     = 1'b1;
        dout_n    = 1'b1;
        wtbt_n    = 1'b1;
        ad_oe     = 1'b0;
        ad_out_n  = AD_IDLE_N;
        unique case (state)
            S_IDLE: req_ready = 1'b1;
            S_ADDR, S_SYNC: begin
                ad_oe    = 1'b1;
                ad_out_n = ~addr_q;
                wtbt_n   = ~is_write;
                sync_n   = (state != S_SYNC);
            end
            S_DATA, S_END: begin
                sync_n = 1'b0;
                if (is_write) begin
                    ad_oe    = 1'b1;
                    ad_out_n = ~lane_data(byte_q, addr_q[0], wdata_q);
                    wtbt_n   = ~byte_q;
                    dout_n   = (state != S_DATA);
                end else begin
                    din_n = (state != S_DATA);
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qbus_master.sv
// tb_qbus_master: directed and randomized transfers against a behavioural
// responder and a timing/lane reference model.
module tb_qbus_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        done;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    logic [15:0] ad_in_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        rply_n;

    int checks = 0;
    int errors = 0;

    bit          silent;
    bit          stale;
    int          r_delay;
    int          r_release;
    logic [15:0] r_data;

    always #5 clk = ~clk;

    qbus_master #(.TIMEOUT(TO)) dut (
        .pin_clk_p  (clk),
        .pin_dclo_n (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .ad_out_n   (ad_out_n),
        .ad_oe      (ad_oe),
        .ad_in_n    (ad_in_n),
        .sync_n     (sync_n),
        .din_n      (din_n),
        .dout_n     (dout_n),
        .wtbt_n     (wtbt_n),
        .rply_n     (rply_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder: replies r_delay cycles after a strobe falls, releases
    // r_release cycles after the strobe rises.
    initial begin
        rply_n  = 1'b1;
        ad_in_n = '1;
        forever begin
            @(negedge clk);
            if (rst_n && !silent && (!din_n || !dout_n)) begin
                if (stale) begin
                    repeat (5) @(negedge clk);
                    rply_n = 1'b1;
                    repeat (2) @(negedge clk);
                end
                repeat (r_delay) @(negedge clk);
                ad_in_n = ~r_data;
                rply_n  = 1'b0;
                while (!din_n || !dout_n) @(negedge clk);
                repeat (r_release) @(negedge clk);
                rply_n  = 1'b1;
                ad_in_n = '1;
            end else begin
                rply_n = !stale;
            end
        end
    end

    task automatic run_txn(
        input logic        wr,
        input logic        byt,
        input logic [15:0] addr,
        input logic [15:0] wdata,
        input logic [15:0] rd,
        input int          d,
        input int          r,
        input bit          chk_lat
    );
        logic [15:0] exp_bus;
        logic [15:0] bus;
        int          n;
        bit          got_done;
        bit          data_seen;
        bit          rply_low;
        bit          overlap;
        bit          prev_sync;
        bit          prev_str;
        bit          str;
        if (!byt || !wr) exp_bus = wdata;
        else if (addr[0]) exp_bus = {wdata[7:0], 8'h00};
        else exp_bus = {8'h00, wdata[7:0]};
        r_delay   = d;
        r_release = r;
        r_data    = rd;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_byte  = ~byt;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        n = 1;
        got_done = 0;
        data_seen = 0;
        rply_low = 0;
        overlap = 0;
        prev_sync = 1;
        prev_str = 0;
        while (!got_done && n < 400) begin
            bus = ~ad_out_n;
            str = !din_n || !dout_n;
            if (!sync_n && prev_sync) begin
                check("sync_fall_addr", bus, addr);
                check("sync_fall_wtbt", wtbt_n, !wr);
            end
            if (str && !data_seen) begin
                data_seen = 1;
                if (wr) begin
                    check("data_bus", bus, exp_bus);
                    check("data_wtbt", wtbt_n, !byt);
                    check("data_oe", {ad_oe, dout_n, din_n}, 3'b101);
                end else begin
                    check("read_oe", {ad_oe, wtbt_n, din_n, dout_n}, 4'b0101);
                end
            end
            if (str && !rply_n) rply_low = 1;
            if (!din_n && !dout_n) overlap = 1;
            if (prev_str && !str) check("release_after_rply", rply_low, 1);
            prev_str = str;
            if (done) begin
                got_done = 1;
            end else begin
                prev_sync = sync_n;
                @(negedge clk);
                n++;
            end
        end
        check("done_seen", got_done, 1);
        check("strobe_seen", data_seen, 1);
        check("one_strobe", overlap, 0);
        if (chk_lat) check("latency", n, 9 + d + r);
        check("done_err", err, 0);
        check("done_bus", {sync_n, ad_oe, wtbt_n}, 3'b101);
        if (!wr) check("rdata", rdata, rd);
        @(negedge clk);
        check("done_pulse", done, 0);
        if (!wr) check("rdata_hold", rdata, rd);
    endtask

    initial begin
        int n;
        int gap;
        int run;
        int acc;
        int dn;
        int falls;
        bit drop;
        bit prev_sync;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        silent    = 0;
        stale     = 0;
        r_delay   = 0;
        r_release = 0;
        r_data    = '0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'hF);
        check("rst_oe", ad_oe, 0);
        check("rst_ad", ad_out_n, 16'hFFFF);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);

        run_txn(1'b1, 1'b0, 16'o001000, 16'h1234, 16'h0000, 2, 0, 1);
        run_txn(1'b0, 1'b0, 16'o177564, 16'h0000, 16'o000200, 0, 0, 1);
        run_txn(1'b1, 1'b1, 16'o001001, 16'h00AB, 16'h0000, 1, 1, 1);
        run_txn(1'b1, 1'b1, 16'o001000, 16'h55AB, 16'h0000, 0, 0, 1);

        stale = 1;
        run_txn(1'b0, 1'b0, 16'o000400, 16'h0000, 16'hBEEF, 0, 0, 0);
        stale = 0;

        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), $urandom_range(0, 6), $urandom_range(0, 4), 1);
        end

        r_delay   = 0;
        r_release = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'o002000;
        req_wdata = 16'h5A5A;
        acc = 0;
        dn = 0;
        drop = 0;
        falls = 0;
        run = 0;
        gap = 0;
        prev_sync = 1;
        for (int c = 0; c < 100; c++) begin
            if (done) dn++;
            if (sync_n) begin
                run++;
            end else begin
                if (prev_sync) begin
                    falls++;
                    if (falls == 2) gap = run;
                end
                run = 0;
            end
            prev_sync = sync_n;
            if (drop) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) drop = 1;
            end
            @(negedge clk);
        end
        check("b2b_accepts", acc, 2);
        check("b2b_done", dn, 2);
        check("b2b_falls", falls, 2);
        check("b2b_gap_ge2", gap >= 2, 1);

        silent = 1;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'o000100;
        req_wdata = 16'hCAFE;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (dout_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_dout_low", dout_n, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {sync_n, din_n, dout_n, wtbt_n, ad_oe}, 5'b11110);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        check("mid_rst_hold", {done, ad_oe, sync_n}, 3'b001);
        silent    = 0;
        r_delay   = 0;
        r_release = 0;
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_wdata = 16'h0F0F;
        #1;
        check("rel_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("rel_accept", {ad_oe, sync_n}, 2'b11);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rel_done", done, 1);

        silent = 1;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'o177560;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef QBUS_MASTER_TIMEOUT_EN
        n = 0;
        dn = 0;
        while (!done && n < 200) begin
            if (!din_n) dn++;
            @(negedge clk);
            n++;
        end
        check("tmo_din_cycles", dn, TO);
        check("tmo_done", done, 1);
        check("tmo_err", err, 1);
        check("tmo_sync", sync_n, 1);
`else
        dn = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("hang_din", din_n, 0);
        check("hang_sync", sync_n, 0);
        check("hang_done", dn, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        silent = 0;
        @(negedge clk);
        check("final_idle", {req_ready, sync_n}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
